uart_tx_frame_ctrl: RTL and testbench

- Sequences one UART transmit frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Generates its own baud timing from the system clock and accepts bytes over a valid/ready handshake.
- Exports a running bit count, so frame length is 10 bits without parity and 11 bits with parity.
- Sits between the TX FIFO/CPU register interface and the tx pin.

---
 rtl/uart_tx_frame_ctrl_if.sv | 23 ++
 rtl/uart_tx_frame_ctrl.sv | 102 ++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte handshake, frame configuration and serial-line status between the TX FIFO/CPU side
// and the UART frame controller.
interface uart_tx_frame_ctrl_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic [3:0] bit_used_i;
  logic       parity_odd_i;
  logic       tx_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [3:0] bit_cnt_o;
  logic       done_o;

  modport slave (
    input  tx_valid_i, tx_data_i, bit_used_i, parity_odd_i,
    output tx_ready_o, tx_o, busy_o, bit_cnt_o, done_o
  );

  modport master (
    output tx_valid_i, tx_data_i, bit_used_i, parity_odd_i,
    input  tx_ready_o, tx_o, busy_o, bit_cnt_o, done_o
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits LSB-first, optional parity, stop,
// with an internal baud divider and a valid/ready byte intake.
module uart_tx_frame_ctrl #(
  parameter int unsigned CLK_DIV = 434
) (
  input logic                  clk_i,
  input logic                  rst_i,
  uart_tx_frame_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] baud, baud_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par_en, par_en_n;
  logic        par_bit, par_bit_n;
  logic        done, done_n;
  logic        tick;
  logic        tx_line;

  assign tick = (baud == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_en  <= par_en_n;
      par_bit <= par_bit_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_en_n  = par_en;
    par_bit_n = par_bit;
    done_n    = 1'b0;
    if (state == IDLE) begin
      if (bus.tx_valid_i) begin
        state_n   = START;
        baud_n    = '0;
        bit_cnt_n = '0;
        shift_n   = bus.tx_data_i;
        par_en_n  = (bus.bit_used_i == 4'd9);
        // Parity is fixed at accept time because the shift register is consumed during DATA.
        par_bit_n = (^bus.tx_data_i) ^ bus.parity_odd_i;
      end
    end else if (tick) begin
      baud_n    = '0;
      bit_cnt_n = bit_cnt + 4'd1;
      case (state)
        START:  state_n = DATA;
        DATA: begin
          shift_n = shift >> 1;
          if (bit_cnt == 4'd8) state_n = par_en ? PARITY : STOP;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      baud_n = baud + 16'd1;
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = shift[0];
      PARITY:  tx_line = par_bit;
      default: tx_line = 1'b1;
    endcase
  end

  assign bus.tx_o       = tx_line;
  assign bus.tx_ready_o = (state == IDLE);
  assign bus.busy_o     = (state != IDLE);
  assign bus.bit_cnt_o  = bit_cnt;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl with a 4-cycle bit period.
module tb_uart_tx_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen;

  uart_tx_frame_ctrl_if bus();

  uart_tx_frame_ctrl #(.CLK_DIV(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [3:0] cnt);
    check({tag, "_tx"}, 16'(bus.tx_o), 16'd1);
    check({tag, "_ready"}, 16'(bus.tx_ready_o), 16'd1);
    check({tag, "_busy"}, 16'(bus.busy_o), 16'd0);
    check({tag, "_bitcnt"}, 16'(bus.bit_cnt_o), 16'(cnt));
    check({tag, "_done"}, 16'(bus.done_o), 16'd0);
  endtask

  // Called right after the accept edge; returns in the done_o cycle.
  task automatic frame_checks(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic scramble);
    int n;
    logic [10:0] bits;
    n = pen ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) bits[9] = pbit;
    for (int j = 0; j < n * 4; j++) begin
      check($sformatf("tx_bit_j%0d", j), 16'(bus.tx_o), 16'(bits[j/4]));
      check($sformatf("bitcnt_j%0d", j), 16'(bus.bit_cnt_o), 16'(j / 4));
      check($sformatf("busy_j%0d", j), 16'(bus.busy_o), 16'd1);
      check($sformatf("ready_j%0d", j), 16'(bus.tx_ready_o), 16'd0);
      check($sformatf("done_j%0d", j), 16'(bus.done_o), 16'd0);
      if (scramble && j == 10) begin
        bus.tx_data_i    = 8'h3C;
        bus.bit_used_i   = 4'd5;
        bus.parity_odd_i = 1'b0;
        bus.tx_valid_i   = 1'b1;
      end
      tick();
    end
    check("end_done", 16'(bus.done_o), 16'd1);
    check("end_bitcnt", 16'(bus.bit_cnt_o), 16'(n));
    check("end_ready", 16'(bus.tx_ready_o), 16'd1);
    check("end_busy", 16'(bus.busy_o), 16'd0);
    check("end_tx", 16'(bus.tx_o), 16'd1);
  endtask

  task automatic accept(input logic [7:0] d, input logic [3:0] bu, input logic odd);
    bus.tx_data_i    = d;
    bus.bit_used_i   = bu;
    bus.parity_odd_i = odd;
    bus.tx_valid_i   = 1'b1;
    tick();
    bus.tx_valid_i   = 1'b0;
  endtask

  initial begin
    bus.tx_valid_i   = 1'b0;
    bus.tx_data_i    = 8'h00;
    bus.bit_used_i   = 4'd8;
    bus.parity_odd_i = 1'b0;

    // Reset and idle hold
    rst = 1'b1;
    repeat (3) tick();
    check_idle("reset", 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle", 4'd0);
    end

    // 0xA5 without parity: line 0,1,0,1,0,0,1,0,1,1
    accept(8'hA5, 4'd8, 1'b0);
    frame_checks(8'hA5, 1'b0, 1'b0, 1'b0);
    tick();
    check_idle("after_a5", 4'd10);

    // 0x07 with even then odd parity
    accept(8'h07, 4'd9, 1'b0);
    frame_checks(8'h07, 1'b1, 1'b1, 1'b0);
    tick();
    check_idle("after_even", 4'd11);
    accept(8'h07, 4'd9, 1'b1);
    frame_checks(8'h07, 1'b1, 1'b0, 1'b0);
    tick();
    check_idle("after_odd", 4'd11);

    // Back-to-back with valid held high
    bus.tx_data_i  = 8'h00;
    bus.bit_used_i = 4'd8;
    bus.tx_valid_i = 1'b1;
    tick();
    bus.tx_data_i  = 8'hFF;
    frame_checks(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    bus.tx_valid_i = 1'b0;
    frame_checks(8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    check_idle("after_b2b", 4'd10);

    // Mid-frame input changes, then accept with bit_used=5 in the done cycle
    accept(8'hA5, 4'd9, 1'b1);
    frame_checks(8'hA5, 1'b1, 1'b1, 1'b1);
    tick();
    bus.tx_valid_i = 1'b0;
    frame_checks(8'h3C, 1'b0, 1'b0, 1'b0);
    tick();
    check_idle("after_illegal", 4'd10);

    // Reset during data bit 3
    accept(8'hFF, 4'd8, 1'b0);
    repeat (17) tick();
    check("pre_rst_tx", 16'(bus.tx_o), 16'd1);
    check("pre_rst_bitcnt", 16'(bus.bit_cnt_o), 16'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst", 4'd0);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.done_o) done_seen++;
    end
    check("midrst_no_done", 16'(done_seen), 16'd0);
    check_idle("midrst_final", 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
